// File: rtl/stopwatch_pkg.sv
// Shared constants and the BCD-to-segment table for the stopwatch display path.
package stopwatch_pkg;

   localparam int         NUM_DIGITS = 6;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [6:0] SEG_DASH   = 7'h3F;

   localparam logic [2:0] DIG_MS_ONES  = 3'd0;
   localparam logic [2:0] DIG_MS_TENS  = 3'd1;
   localparam logic [2:0] DIG_SEC_ONES = 3'd2;
   localparam logic [2:0] DIG_SEC_TENS = 3'd3;
   localparam logic [2:0] DIG_MIN_ONES = 3'd4;
   localparam logic [2:0] DIG_MIN_TENS = 3'd5;

   // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
   function automatic logic [6:0] bcd_seg(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/stopwatch_seg7_scan_bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern, dash for non-decimal codes.
module bcd_to_seg7
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = bcd_seg(bcd);
   end

endmodule

// File: rtl/stopwatch_seg7_scan.sv
// Multiplexes a frozen-per-frame MM.SS.hh snapshot onto a 6-digit common-anode display.
module stopwatch_seg7_scan
   import stopwatch_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                  clk_core,
   input  logic                  rst,
   input  logic [7:0]            min_i,
   input  logic [7:0]            sec_i,
   input  logic [7:0]            ms_10_i,
   input  logic                  lap_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic                  lap_active_o
);

   localparam int            PW         = $clog2(SCAN_DIV + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0]         presc;
   logic                  tick;
   logic [2:0]            idx;
   logic                  wrap;
   logic                  first_pend;
   logic                  load;
   logic [23:0]           snapshot;
   logic                  lap_s1;
   logic                  lap_s2;
   logic                  lap_prev;
   logic                  lap_edge;
   logic                  hold;
   logic [3:0]            nibble;
   logic [6:0]            dec_seg;
   logic [6:0]            next_seg;
   logic                  next_dp;
   logic [NUM_DIGITS-1:0] next_an;

   assign tick     = (presc == PRESC_LAST);
   assign wrap     = tick && (idx == DIG_MIN_TENS);
   assign lap_edge = lap_s2 && !lap_prev;
   // Sampling hold before its own update lets a lap edge on a wrap still capture that frame.
   assign load     = tick && (wrap || first_pend) && !hold;

   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         presc      <= '0;
         idx        <= DIG_MS_ONES;
         first_pend <= 1'b1;
      end else begin
         if (tick) begin
            presc      <= '0;
            idx        <= wrap ? DIG_MS_ONES : idx + 3'd1;
            first_pend <= 1'b0;
         end else begin
            presc      <= presc + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         snapshot <= 24'h0;
         lap_s1   <= 1'b0;
         lap_s2   <= 1'b0;
         lap_prev <= 1'b0;
         hold     <= 1'b0;
      end else begin
         if (load) begin
            snapshot <= {min_i, sec_i, ms_10_i};
         end
         lap_s1   <= lap_i;
         lap_s2   <= lap_s1;
         lap_prev <= lap_s2;
         hold     <= hold ^ lap_edge;
      end
   end

   always_comb begin
      nibble = snapshot[3:0];
      case (idx)
         DIG_MS_ONES:  nibble = snapshot[3:0];
         DIG_MS_TENS:  nibble = snapshot[7:4];
         DIG_SEC_ONES: nibble = snapshot[11:8];
         DIG_SEC_TENS: nibble = snapshot[15:12];
         DIG_MIN_ONES: nibble = snapshot[19:16];
         DIG_MIN_TENS: nibble = snapshot[23:20];
         default:      nibble = snapshot[3:0];
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (nibble),
      .seg (dec_seg)
   );

   // Decimal points sit after the minutes-ones and seconds-ones digits.
   always_comb begin
      next_an  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
      next_seg = dec_seg;
      next_dp  = !((idx == DIG_SEC_ONES) || (idx == DIG_MIN_ONES));
      if (BLANK_LZ && (idx == DIG_MIN_TENS) && (snapshot[23:20] == 4'd0)) begin
         next_seg = SEG_BLANK;
      end
   end

   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         seg_o <= SEG_BLANK;
         dp_o  <= 1'b1;
         an_o  <= '1;
      end else begin
         seg_o <= next_seg;
         dp_o  <= next_dp;
         an_o  <= next_an;
      end
   end

   assign lap_active_o = hold;

endmodule

// File: tb/tb_stopwatch_seg7_scan.sv
// Directed bench: SCAN_DIV=4 blanking instance for scan/lap/blank, SCAN_DIV=1 instance for wrap-aligned lap.
module tb_stopwatch_seg7_scan;

   logic       clk_core = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] min4 = 8'h00, sec4 = 8'h00, ms4 = 8'h00;
   logic       lap4 = 1'b0;
   logic [6:0] seg4;
   logic       dp4;
   logic [5:0] an4;
   logic       lapact4;
   logic [7:0] min1 = 8'h23, sec1 = 8'h11, ms1 = 8'h44;
   logic       lap1 = 1'b0;
   logic [6:0] seg1;
   logic       dp1;
   logic [5:0] an1;
   logic       lapact1;

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [5:0] AN_TAB   [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
   localparam logic       DP_TAB   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   // 12:34.56, 59:59.99, 05:00.0A (blanked), and 07:42.18 unblanked, indexed by digit slot.
   localparam logic [6:0] SEGA_TAB [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
   localparam logic [6:0] SEGB_TAB [6] = '{7'h10, 7'h10, 7'h10, 7'h12, 7'h10, 7'h12};
   localparam logic [6:0] SEGL_TAB [6] = '{7'h3F, 7'h40, 7'h40, 7'h40, 7'h12, 7'h7F};
   localparam logic [6:0] SEGZ_TAB [6] = '{7'h00, 7'h79, 7'h24, 7'h19, 7'h78, 7'h40};

   always #5 clk_core = ~clk_core;

   stopwatch_seg7_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut4 (
      .clk_core     (clk_core),
      .rst          (rst),
      .min_i        (min4),
      .sec_i        (sec4),
      .ms_10_i      (ms4),
      .lap_i        (lap4),
      .seg_o        (seg4),
      .dp_o         (dp4),
      .an_o         (an4),
      .lap_active_o (lapact4)
   );

   stopwatch_seg7_scan #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut1 (
      .clk_core     (clk_core),
      .rst          (rst),
      .min_i        (min1),
      .sec_i        (sec1),
      .ms_10_i      (ms1),
      .lap_i        (lap1),
      .seg_o        (seg1),
      .dp_o         (dp1),
      .an_o         (an1),
      .lap_active_o (lapact1)
   );

   task automatic do_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk_core);
      @(negedge clk_core);
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (an4 !== 6'h3F) begin tests_failed++; $display("[TB] FAIL reset_an: got %h want 3f", an4); end
      tests_run++;
      if (seg4 !== 7'h7F) begin tests_failed++; $display("[TB] FAIL reset_seg: got %h want 7f", seg4); end
      tests_run++;
      if (dp4 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_dp: got %b want 1", dp4); end
      tests_run++;
      if (lapact4 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_lap: got %b want 0", lapact4); end
      repeat (3) @(posedge clk_core);
      #1;
      tests_run++;
      if (an1 !== 6'h3F) begin tests_failed++; $display("[TB] FAIL reset_hold_an1: got %h want 3f", an1); end
   endtask

   task automatic test_scan;
      min4 = 8'h12; sec4 = 8'h34; ms4 = 8'h56; lap4 = 1'b0;
      do_reset();
      for (int n = 1; n <= 48; n++) begin
         @(posedge clk_core);
         #1;
         if (n % 4 == 1) begin
            int k;
            logic [6:0] es;
            k = (n - 1) / 4;
            es = (k == 0) ? 7'h40 : SEGA_TAB[k % 6];
            tests_run++;
            if (an4 !== AN_TAB[k % 6]) begin tests_failed++; $display("[TB] FAIL scan_an slot %0d: got %h want %h", k, an4, AN_TAB[k % 6]); end
            tests_run++;
            if (seg4 !== es) begin tests_failed++; $display("[TB] FAIL scan_seg slot %0d: got %h want %h", k, seg4, es); end
            tests_run++;
            if (dp4 !== DP_TAB[k % 6]) begin tests_failed++; $display("[TB] FAIL scan_dp slot %0d: got %b want %b", k, dp4, DP_TAB[k % 6]); end
         end else if (n % 4 == 0) begin
            tests_run++;
            if (an4 !== AN_TAB[(n / 4 - 1) % 6]) begin tests_failed++; $display("[TB] FAIL scan_hold cycle %0d: got %h want %h", n, an4, AN_TAB[(n / 4 - 1) % 6]); end
         end
      end
   endtask

   task automatic test_coherency;
      min4 = 8'h12; sec4 = 8'h34; ms4 = 8'h56; lap4 = 1'b0;
      do_reset();
      for (int n = 1; n <= 72; n++) begin
         @(posedge clk_core);
         #1;
         if (n % 4 == 1 && n >= 37) begin
            int k;
            logic [6:0] es;
            k = (n - 1) / 4;
            es = (k < 12) ? SEGA_TAB[k % 6] : SEGB_TAB[k % 6];
            tests_run++;
            if (seg4 !== es || an4 !== AN_TAB[k % 6]) begin
               tests_failed++;
               $display("[TB] FAIL coherency slot %0d: got an=%h seg=%h want an=%h seg=%h", k, an4, seg4, AN_TAB[k % 6], es);
            end
         end
         if (n == 37) begin
            min4 = 8'h59; sec4 = 8'h59; ms4 = 8'h99;
         end
      end
   endtask

   task automatic test_lap;
      int first_seen;
      first_seen = 0;
      min4 = 8'h12; sec4 = 8'h34; ms4 = 8'h56; lap4 = 1'b0;
      do_reset();
      for (int n = 1; n <= 141; n++) begin
         @(posedge clk_core);
         #1;
         if (n >= 30 && n <= 33 && lapact4 === 1'b1 && first_seen == 0) first_seen = n;
         if (n == 33) begin
            tests_run++;
            if (first_seen == 0) begin tests_failed++; $display("[TB] FAIL lap_rise: lap_active_o=%b after 4 cycles, want 1", lapact4); end
            min4 = 8'h59; sec4 = 8'h59; ms4 = 8'h99;
         end
         if (n % 4 == 1 && n >= 37) begin
            int k;
            logic [6:0] es;
            k = (n - 1) / 4;
            es = (k < 30) ? SEGA_TAB[k % 6] : SEGB_TAB[k % 6];
            tests_run++;
            if (seg4 !== es || an4 !== AN_TAB[k % 6]) begin
               tests_failed++;
               $display("[TB] FAIL lap_display slot %0d: got an=%h seg=%h want an=%h seg=%h", k, an4, seg4, AN_TAB[k % 6], es);
            end
         end
         if (n == 105) begin
            tests_run++;
            if (lapact4 !== 1'b1) begin tests_failed++; $display("[TB] FAIL lap_held: got %b want 1", lapact4); end
         end
         if (n == 110) begin
            tests_run++;
            if (lapact4 !== 1'b0) begin tests_failed++; $display("[TB] FAIL lap_release: got %b want 0", lapact4); end
         end
         if (n == 29 || n == 106) lap4 = 1'b1;
         if (n == 32 || n == 109) lap4 = 1'b0;
      end
   endtask

   task automatic test_blank_dash;
      min4 = 8'h05; sec4 = 8'h00; ms4 = 8'h0A; lap4 = 1'b0;
      do_reset();
      for (int n = 1; n <= 45; n++) begin
         @(posedge clk_core);
         #1;
         if (n % 4 == 1 && n >= 25) begin
            int k;
            k = (n - 1) / 4;
            tests_run++;
            if (an4 !== AN_TAB[k % 6]) begin tests_failed++; $display("[TB] FAIL blank_an slot %0d: got %h want %h", k, an4, AN_TAB[k % 6]); end
            tests_run++;
            if (seg4 !== SEGL_TAB[k % 6]) begin tests_failed++; $display("[TB] FAIL blank_seg slot %0d: got %h want %h", k, seg4, SEGL_TAB[k % 6]); end
         end
      end
   endtask

   task automatic test_reset_mid_scan;
      min4 = 8'h12; sec4 = 8'h34; ms4 = 8'h56; lap4 = 1'b0;
      do_reset();
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk_core);
         #1;
         if (n == 10) lap4 = 1'b1;
         if (n == 13) lap4 = 1'b0;
      end
      tests_run++;
      if (lapact4 !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_setup: lap_active_o=%b want 1", lapact4); end
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (an4 !== 6'h3F || seg4 !== 7'h7F || dp4 !== 1'b1 || lapact4 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midreset_outputs: got an=%h seg=%h dp=%b lap=%b want 3f 7f 1 0", an4, seg4, dp4, lapact4);
      end
      @(negedge clk_core);
      rst = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk_core);
         #1;
         if (n == 1 || n == 4) begin
            tests_run++;
            if (an4 !== 6'h3E || seg4 !== 7'h40) begin tests_failed++; $display("[TB] FAIL midreset_resume cycle %0d: got an=%h seg=%h want 3e 40", n, an4, seg4); end
         end
         if (n == 5) begin
            tests_run++;
            if (an4 !== 6'h3D || seg4 !== 7'h12) begin tests_failed++; $display("[TB] FAIL midreset_first_tick: got an=%h seg=%h want 3d 12", an4, seg4); end
         end
      end
   endtask

   task automatic test_div1_lap_on_wrap;
      bit found;
      found = 1'b0;
      min1 = 8'h23; sec1 = 8'h11; ms1 = 8'h44; lap1 = 1'b0;
      do_reset();
      repeat (14) @(posedge clk_core);
      #1;
      // an_o lags idx by one cycle, so showing slot 2 means idx reaches 5 two cycles later.
      for (int i = 0; i < 12 && !found; i++) begin
         @(posedge clk_core);
         #1;
         if (an1 === 6'h3B) found = 1'b1;
      end
      tests_run++;
      if (!found) begin tests_failed++; $display("[TB] FAIL div1_align: an_o never showed 3b, last %h", an1); end
      if (found) begin
         lap1 = 1'b1;
         min1 = 8'h07; sec1 = 8'h42; ms1 = 8'h18;
         repeat (3) @(posedge clk_core);
         #1;
         min1 = 8'h59; sec1 = 8'h59; ms1 = 8'h99;
         tests_run++;
         if (lapact1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL div1_lap_active: got %b want 1", lapact1); end
         for (int j = 1; j <= 12; j++) begin
            @(posedge clk_core);
            #1;
            if (j == 3) lap1 = 1'b0;
            tests_run++;
            if (an1 !== AN_TAB[(j - 1) % 6] || seg1 !== SEGZ_TAB[(j - 1) % 6]) begin
               tests_failed++;
               $display("[TB] FAIL div1_frozen cycle %0d: got an=%h seg=%h want an=%h seg=%h", j, an1, seg1, AN_TAB[(j - 1) % 6], SEGZ_TAB[(j - 1) % 6]);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_scan();
      test_coherency();
      test_lap();
      test_blank_dash();
      test_reset_mid_scan();
      test_div1_lap_on_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
